// File: rtl/counter_sequencer_if.sv
// Command handshake bundle for counter_sequencer: valid/ready plus opcode, value and step count.
interface counter_sequencer_if #(
    parameter int NBITS_COUNT = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [NBITS_COUNT-1:0] cmd_value;
    logic [NBITS_COUNT-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_value,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_value,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/counter_sequencer.sv
// Command-driven controller for the loadable up/down counter: LOAD, stepped UP/DOWN runs,
// free-running count with halt, and busy/done/wrap status for the display logic.
module counter_sequencer #(
    parameter int NBITS_COUNT = 4
) (
    input  logic                   clk_2,
    input  logic                   reset,
    counter_sequencer_if.slave     cmd,
    input  logic                   halt,
    output logic [NBITS_COUNT-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   wrapped,
    output logic [1:0]             state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FREE = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_FREE = 2'b11;

    localparam logic [NBITS_COUNT-1:0] COUNT_MAX = '1;
    localparam logic [NBITS_COUNT-1:0] ONE       = {{(NBITS_COUNT-1){1'b0}}, 1'b1};

    state_t                 state_reg, state_next;
    logic [NBITS_COUNT-1:0] count_reg, count_next;
    logic [NBITS_COUNT-1:0] remaining_reg, remaining_next;
    logic                   dir_reg, dir_next;
    logic                   wrapped_reg, wrapped_next;

    logic                   accept;
    logic [NBITS_COUNT-1:0] step_count;
    logic                   step_wraps;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
            wrapped_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            wrapped_reg   <= wrapped_next;
        end
    end

    // ready depends only on the registered state, so there is no valid->ready path
    assign accept     = cmd.cmd_valid && (state_reg == IDLE);
    assign step_count = dir_reg ? (count_reg + ONE) : (count_reg - ONE);
    assign step_wraps = dir_reg ? (count_reg == COUNT_MAX) : (count_reg == '0);

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        wrapped_next   = wrapped_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    wrapped_next = 1'b0;
                    case (cmd.cmd_op)
                        OP_LOAD: begin
                            count_next = cmd.cmd_value;
                            state_next = DONE;
                        end
                        OP_UP, OP_DOWN: begin
                            dir_next       = (cmd.cmd_op == OP_UP);
                            remaining_next = cmd.cmd_steps;
                            state_next     = (cmd.cmd_steps == '0) ? DONE : RUN;
                        end
                        default: begin
                            dir_next   = cmd.cmd_value[0];
                            state_next = FREE;
                        end
                    endcase
                end
            end
            RUN, FREE: begin
                // halt wins over the step scheduled for this edge
                if (halt) begin
                    remaining_next = '0;
                    state_next     = DONE;
                end else begin
                    count_next = step_count;
                    if (step_wraps) begin
                        wrapped_next = 1'b1;
                    end
                    if (state_reg == RUN) begin
                        remaining_next = remaining_reg - ONE;
                        if (remaining_reg <= ONE) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready = (state_reg == IDLE);
    assign busy          = (state_reg == RUN) || (state_reg == FREE);
    assign done          = (state_reg == DONE);
    assign count         = count_reg;
    assign wrapped       = wrapped_reg;
    assign state         = state_reg;
endmodule
